// File: rtl/core_pkg.sv
// rtl/core_pkg.sv - shared types for the core front end
package core_pkg;

    typedef enum logic [2:0] {
        IDLE,
        REQ,
        WAIT,
        HOLD,
        DRAIN
    } fetch_state_e;

endpackage

// File: rtl/core_fetch.sv
// rtl/core_fetch.sv - instruction fetch front end: owns the fetch PC, one imem read in flight, buffers to decode
module core_fetch
    import core_pkg::*;
#(
    parameter logic [31:0] RESET_PC = 32'h8000_0000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        pc_new_valid,
    input  logic [31:0] pc_new,
    output logic        imem_req_valid,
    input  logic        imem_req_ready,
    output logic [31:0] imem_req_addr,
    input  logic        imem_rsp_valid,
    input  logic [31:0] imem_rsp_data,
    input  logic        imem_rsp_err,
    output logic        if_valid,
    input  logic        if_ready,
    output logic [31:0] if_instr,
    output logic [31:0] if_pc,
    output logic        if_fault
);

    fetch_state_e state, state_d;
    logic [31:0]  pc, pc_d;
    logic         buf_we;
    logic [31:0]  buf_instr_d;
    logic [31:0]  buf_pc_d;
    logic         buf_fault_d;
    logic         pc_aligned;
    logic         req_fire;

    assign pc_aligned     = (pc[1:0] == 2'b00);
    assign imem_req_valid = (state == REQ) && pc_aligned;
    assign imem_req_addr  = pc;
    assign if_valid       = (state == HOLD);
    assign req_fire       = imem_req_valid && imem_req_ready;

    always_comb begin
        state_d     = state;
        pc_d        = pc;
        buf_we      = 1'b0;
        buf_instr_d = 32'h0;
        buf_pc_d    = pc;
        buf_fault_d = 1'b0;

        case (state)
            IDLE: state_d = REQ;

            REQ: begin
                if (!pc_aligned) begin
                    // A misaligned PC is reported in place; a same-cycle redirect retries instead.
                    if (!pc_new_valid) begin
                        buf_we      = 1'b1;
                        buf_fault_d = 1'b1;
                        state_d     = HOLD;
                    end
                end else if (req_fire) begin
                    state_d = pc_new_valid ? DRAIN : WAIT;
                end
            end

            WAIT: begin
                if (imem_rsp_valid) begin
                    if (pc_new_valid) begin
                        state_d = REQ;
                    end else begin
                        buf_we      = 1'b1;
                        buf_instr_d = imem_rsp_err ? 32'h0 : imem_rsp_data;
                        buf_fault_d = imem_rsp_err;
                        pc_d        = pc + 32'd4;
                        state_d     = HOLD;
                    end
                end else if (pc_new_valid) begin
                    state_d = DRAIN;
                end
            end

            HOLD: begin
                if (if_ready || pc_new_valid) begin
                    state_d = REQ;
                end
            end

            DRAIN: begin
                // The stale response must be absorbed before the next request can go out.
                if (imem_rsp_valid) begin
                    state_d = REQ;
                end
            end

            default: state_d = IDLE;
        endcase

        if (pc_new_valid) begin
            pc_d = pc_new;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= IDLE;
            pc       <= RESET_PC;
            if_instr <= 32'h0;
            if_pc    <= 32'h0;
            if_fault <= 1'b0;
        end else begin
            state <= state_d;
            pc    <= pc_d;
            if (buf_we) begin
                if_instr <= buf_instr_d;
                if_pc    <= buf_pc_d;
                if_fault <= buf_fault_d;
            end
        end
    end

endmodule

// File: tb/tb_core_fetch.sv
// tb/tb_core_fetch.sv - randomized scoreboard bench for core_fetch
module tb_core_fetch;

    localparam logic [31:0] RESET_PC = 32'h8000_0000;

    logic        clk;
    logic        rst;
    logic        pc_new_valid;
    logic [31:0] pc_new;
    logic        imem_req_valid;
    logic        imem_req_ready;
    logic [31:0] imem_req_addr;
    logic        imem_rsp_valid;
    logic [31:0] imem_rsp_data;
    logic        imem_rsp_err;
    logic        if_valid;
    logic        if_ready;
    logic [31:0] if_instr;
    logic [31:0] if_pc;
    logic        if_fault;

    core_fetch #(.RESET_PC(RESET_PC)) dut (
        .clk            (clk),
        .rst            (rst),
        .pc_new_valid   (pc_new_valid),
        .pc_new         (pc_new),
        .imem_req_valid (imem_req_valid),
        .imem_req_ready (imem_req_ready),
        .imem_req_addr  (imem_req_addr),
        .imem_rsp_valid (imem_rsp_valid),
        .imem_rsp_data  (imem_rsp_data),
        .imem_rsp_err   (imem_rsp_err),
        .if_valid       (if_valid),
        .if_ready       (if_ready),
        .if_instr       (if_instr),
        .if_pc          (if_pc),
        .if_fault       (if_fault)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] pc;
        logic [31:0] instr;
        logic        fault;
    } item_t;

    item_t exp_q[$];
    int    n_total = 0;
    int    n_pass  = 0;
    int    handshakes = 0;
    bit    run = 0;
    bit    mon_en = 0;

    function automatic logic [31:0] mem_data(input logic [31:0] a);
        return {a[15:0] ^ 16'h1357, a[31:16]} ^ 32'h0000_0013;
    endfunction

    function automatic logic mem_err(input logic [31:0] a);
        return (a[6:2] == 5'h0B);
    endfunction

    // Architectural view: what decode should receive when fetching from address p.
    function automatic item_t mk(input logic [31:0] p);
        item_t it;
        it.pc = p;
        if (p[1:0] != 2'b00) begin
            it.instr = 32'h0;
            it.fault = 1'b1;
        end else begin
            it.fault = mem_err(p);
            it.instr = it.fault ? 32'h0 : mem_data(p);
        end
        return it;
    endfunction

    function automatic logic [31:0] next_pc(input item_t it);
        return (it.pc[1:0] != 2'b00) ? it.pc : it.pc + 32'd4;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    endtask

    // Monitor: compares whatever decode is shown against the head of the expected queue.
    initial begin
        int idle;
        idle = 0;
        forever begin
            @(negedge clk);
            if (mon_en) begin
                idle++;
                if (if_valid) begin
                    if (exp_q.size() == 0) begin
                        chk("unexpected_if_valid", 32'd1, 32'd0);
                    end else begin
                        chk("if_pc", if_pc, exp_q[0].pc);
                        chk("if_instr", if_instr, exp_q[0].instr);
                        chk("if_fault", {31'd0, if_fault}, {31'd0, exp_q[0].fault});
                        if (if_ready) begin
                            item_t done_it;
                            done_it = exp_q.pop_front();
                            exp_q.push_back(mk(next_pc(done_it)));
                            handshakes++;
                            idle = 0;
                        end
                    end
                end
                if (pc_new_valid) begin
                    exp_q.delete();
                    exp_q.push_back(mk(pc_new));
                    idle = 0;
                end
                if (idle > 300) begin
                    chk("progress_timeout", idle, 0);
                    idle = 0;
                end
            end
        end
    end

    // Stimulus: memory model, decode backpressure and redirects.
    initial begin
        bit          pending;
        int          cnt;
        logic [31:0] paddr;
        pending = 0;
        cnt = 0;
        paddr = 32'h0;
        wait (run);
        while (run) begin
            @(negedge clk);
            if (imem_req_valid && imem_req_ready) begin
                chk("one_outstanding", {31'd0, pending}, 32'd0);
                chk("req_addr_aligned", {30'd0, imem_req_addr[1:0]}, 32'd0);
                pending = 1;
                paddr = imem_req_addr;
                cnt = $urandom_range(1, 3);
            end
            @(posedge clk);
            #1;
            imem_rsp_valid = 1'b0;
            imem_rsp_data  = $urandom;
            imem_rsp_err   = $urandom_range(0, 1);
            if (pending) begin
                cnt--;
                if (cnt == 0) begin
                    imem_rsp_valid = 1'b1;
                    imem_rsp_data  = mem_data(paddr);
                    imem_rsp_err   = mem_err(paddr);
                    pending = 0;
                end
            end
            imem_req_ready = ($urandom_range(0, 2) != 0);
            if_ready       = $urandom_range(0, 1);
            pc_new_valid   = ($urandom_range(0, 11) == 0);
            case ($urandom_range(0, 5))
                0: pc_new = 32'h8000_0100;
                1: pc_new = 32'h8000_0102;
                2: pc_new = 32'h8000_0200;
                3: pc_new = RESET_PC + {24'd0, 6'($urandom_range(0, 63)), 2'b00};
                4: pc_new = 32'hFFFF_FFF8;
                default: pc_new = $urandom;
            endcase
        end
        pc_new_valid   = 1'b0;
        imem_rsp_valid = 1'b0;
        imem_req_ready = 1'b0;
        if_ready       = 1'b0;
    end

    initial begin
        rst            = 1'b1;
        pc_new_valid   = 1'b0;
        pc_new         = 32'h0;
        imem_req_ready = 1'b0;
        imem_rsp_valid = 1'b0;
        imem_rsp_data  = 32'h0;
        imem_rsp_err   = 1'b0;
        if_ready       = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_req_valid", {31'd0, imem_req_valid}, 32'd0);
        chk("rst_req_addr", imem_req_addr, RESET_PC);
        chk("rst_if_valid", {31'd0, if_valid}, 32'd0);
        chk("rst_if_instr", if_instr, 32'h0);
        chk("rst_if_pc", if_pc, 32'h0);
        chk("rst_if_fault", {31'd0, if_fault}, 32'd0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        exp_q.push_back(mk(RESET_PC));
        mon_en = 1;
        @(negedge clk);
        chk("idle_no_req", {31'd0, imem_req_valid}, 32'd0);
        @(negedge clk);
        chk("first_req_valid", {31'd0, imem_req_valid}, 32'd1);
        chk("first_req_addr", imem_req_addr, RESET_PC);
        run = 1;
        repeat (6000) @(posedge clk);
        run = 0;
        repeat (10) @(posedge clk);
        mon_en = 0;
        chk("enough_handshakes", {31'd0, handshakes > 200}, 32'd1);
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
